// File: rtl/edid_capture_pkg.sv
// Shared types and constants for the EDID capture block: FSM states,
// the fixed EDID header pattern and block geometry.
package edid_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    CHECK,
    DONE,
    ABORT
  } edid_state_t;

  localparam int EDID_BLOCK_BYTES = 128;
  localparam int EDID_EXT_INDEX   = 126;

  // Index 0 is the leftmost byte, so EDID_HEADER[i] is header byte i.
  localparam logic [0:7][7:0] EDID_HEADER = {
    8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00
  };

endpackage

// File: rtl/edid_buffer_ram.sv
// Block buffer for one EDID block: one write port, one registered read port.
// The array has no reset so it maps onto block or distributed RAM.
module edid_buffer_ram #(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [7:0]        wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [7:0]        rdata_o
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  // Read register uses the pre-write array value, so same-address read returns old data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_o <= 8'h00;
    end else begin
      rdata_o <= mem[raddr_i];
    end
  end

endmodule

// File: rtl/edid_capture.sv
// Captures one EDID block from the DDC read-byte stream and validates header and checksum.
// Define EDID_CAPTURE_EXT_COUNT_EN to add the ext_count output (extension block count, byte 126).
module edid_capture
  import edid_pkg::*;
#(
  parameter int NUM_BYTES      = EDID_BLOCK_BYTES,
  parameter int ADDR_W         = 7,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk_4x,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              busy,
  output logic              done,
  output logic              header_ok,
  output logic              checksum_ok,
  output logic              timeout,
  output logic [ADDR_W:0]   byte_count,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
`ifdef EDID_CAPTURE_EXT_COUNT_EN
  ,
  output logic [7:0]        ext_count
`endif
);

  localparam int GAP_W = $clog2(TIMEOUT_CYCLES) + 1;

  edid_state_t      state_q;
  logic             busy_q, done_q, headerOk_q, checksumOk_q, timeout_q;
  logic             headerRun_q;
  logic [7:0]       accum_q;
  logic [ADDR_W:0]  count_q;
  logic [GAP_W-1:0] gapCount_q;
`ifdef EDID_CAPTURE_EXT_COUNT_EN
  logic [7:0]       extCount_q;
`endif

  logic             accept, headerMatch, lastByte, gapExpired;
  logic             headerRun_d;
  logic [7:0]       accum_d;
  logic [ADDR_W:0]  count_d;

  // A start in the same cycle wins over a strobe, so that byte is never written.
  assign accept      = (state_q == CAPTURE) && byte_valid && !start;
  assign accum_d     = accum_q + byte_data;
  assign count_d     = count_q + 1'b1;
  assign headerMatch = (count_q >= (ADDR_W+1)'(8)) ||
                       (byte_data == EDID_HEADER[count_q[2:0]]);
  assign headerRun_d = headerRun_q & headerMatch;
  assign lastByte    = (count_d == (ADDR_W+1)'(NUM_BYTES));
  assign gapExpired  = (gapCount_q == GAP_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_4x) begin
    if (rst) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      headerOk_q   <= 1'b0;
      checksumOk_q <= 1'b0;
      timeout_q    <= 1'b0;
      headerRun_q  <= 1'b0;
      accum_q      <= 8'h00;
      count_q      <= '0;
      gapCount_q   <= '0;
`ifdef EDID_CAPTURE_EXT_COUNT_EN
      extCount_q   <= 8'h00;
`endif
    end else if (start) begin
      state_q      <= CAPTURE;
      busy_q       <= 1'b1;
      done_q       <= 1'b0;
      headerOk_q   <= 1'b0;
      checksumOk_q <= 1'b0;
      timeout_q    <= 1'b0;
      headerRun_q  <= 1'b1;
      accum_q      <= 8'h00;
      count_q      <= '0;
      gapCount_q   <= '0;
`ifdef EDID_CAPTURE_EXT_COUNT_EN
      extCount_q   <= 8'h00;
`endif
    end else begin
      case (state_q)
        CAPTURE: begin
          // A strobe on the expiry cycle still counts as activity.
          if (byte_valid) begin
            count_q     <= count_d;
            accum_q     <= accum_d;
            headerRun_q <= headerRun_d;
            gapCount_q  <= '0;
`ifdef EDID_CAPTURE_EXT_COUNT_EN
            if (count_q == (ADDR_W+1)'(EDID_EXT_INDEX)) begin
              extCount_q <= byte_data;
            end
`endif
            if (lastByte) begin
              state_q <= CHECK;
            end
          end else if (gapExpired) begin
            state_q   <= ABORT;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
          end else begin
            gapCount_q <= gapCount_q + 1'b1;
          end
        end
        CHECK: begin
          checksumOk_q <= (accum_q == 8'h00);
          headerOk_q   <= headerRun_q;
          done_q       <= 1'b1;
          busy_q       <= 1'b0;
          state_q      <= DONE;
        end
        default: begin
        end
      endcase
    end
  end

  edid_buffer_ram #(
    .DEPTH  (NUM_BYTES),
    .ADDR_W (ADDR_W)
  ) u_buffer (
    .clk_i   (clk_4x),
    .rst_i   (rst),
    .we_i    (accept),
    .waddr_i (count_q[ADDR_W-1:0]),
    .wdata_i (byte_data),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  assign busy        = busy_q;
  assign done        = done_q;
  assign header_ok   = headerOk_q;
  assign checksum_ok = checksumOk_q;
  assign timeout     = timeout_q;
  assign byte_count  = count_q;
`ifdef EDID_CAPTURE_EXT_COUNT_EN
  assign ext_count   = extCount_q;
`endif

endmodule

// File: tb/tb_edid_capture.sv
// Self-checking bench for edid_capture: random EDID blocks checked against a
// byte-array model of the block (header compare, modular sum, buffer contents).
module tb_edid_capture;

  logic       clk_4x = 1'b0;
  logic       rst, start, byte_valid;
  logic [7:0] byte_data;
  logic       busy, done, header_ok, checksum_ok, timeout;
  logic [7:0] byte_count;
  logic [6:0] rd_addr;
  logic [7:0] rd_data;
`ifdef EDID_CAPTURE_EXT_COUNT_EN
  logic [7:0] ext_count;
`endif

  int checks = 0;
  int passes = 0;

  logic [7:0] blk      [128];
  logic [7:0] memModel [128];
  logic [7:0] hdrRef   [8];

  edid_capture #(.TIMEOUT_CYCLES(16)) dut (
    .clk_4x      (clk_4x),
    .rst         (rst),
    .start       (start),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .busy        (busy),
    .done        (done),
    .header_ok   (header_ok),
    .checksum_ok (checksum_ok),
    .timeout     (timeout),
    .byte_count  (byte_count),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data)
`ifdef EDID_CAPTURE_EXT_COUNT_EN
    ,
    .ext_count   (ext_count)
`endif
  );

  always #5 clk_4x = ~clk_4x;

  function automatic int modelSum();
    int s = 0;
    for (int i = 0; i < 128; i++) s += blk[i];
    return s % 256;
  endfunction

  function automatic logic modelHeader();
    logic ok = 1'b1;
    for (int i = 0; i < 8; i++) if (blk[i] != hdrRef[i]) ok = 1'b0;
    return ok;
  endfunction

  task automatic fixChecksum();
    int s = 0;
    for (int i = 0; i < 127; i++) s += blk[i];
    blk[127] = 8'((256 - (s % 256)) % 256);
  endtask

  task automatic makeBlock();
    for (int i = 0; i < 8; i++) blk[i] = hdrRef[i];
    for (int i = 8; i < 127; i++) blk[i] = 8'($urandom);
    fixChecksum();
  endtask

  // All stimulus changes on the falling edge; outputs are sampled there too.
  task automatic pulseStart();
    start = 1'b1;
    @(negedge clk_4x);
    start = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] d, input int idx);
    byte_valid = 1'b1;
    byte_data  = d;
    @(negedge clk_4x);
    byte_valid = 1'b0;
    if (idx >= 0) memModel[idx] = d;
  endtask

  task automatic sendBlock(input int n, input int maxGap);
    for (int i = 0; i < n; i++) begin
      applyStimulus(blk[i], i);
      if (i != n - 1) repeat ($urandom_range(0, maxGap)) @(negedge clk_4x);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk_4x);
    checks++; if (busy !== 1'b0) $display("[TB] FAIL reset.busy got %0b exp 0", busy); else passes++;
    checks++; if (done !== 1'b0) $display("[TB] FAIL reset.done got %0b exp 0", done); else passes++;
    checks++; if (header_ok !== 1'b0) $display("[TB] FAIL reset.header_ok got %0b exp 0", header_ok); else passes++;
    checks++; if (checksum_ok !== 1'b0) $display("[TB] FAIL reset.checksum_ok got %0b exp 0", checksum_ok); else passes++;
    checks++; if (timeout !== 1'b0) $display("[TB] FAIL reset.timeout got %0b exp 0", timeout); else passes++;
    checks++; if (byte_count !== 8'd0) $display("[TB] FAIL reset.byte_count got %0d exp 0", byte_count); else passes++;
    checks++; if (rd_data !== 8'h00) $display("[TB] FAIL reset.rd_data got %0h exp 0", rd_data); else passes++;
    rst = 1'b0;
  endtask

  task automatic test_valid_block(input int maxGap);
    int a;
    makeBlock();
    pulseStart();
    sendBlock(128, maxGap);
    checks++; if (done !== 1'b0) $display("[TB] FAIL valid.done_early got %0b exp 0", done); else passes++;
    checks++; if (busy !== 1'b1) $display("[TB] FAIL valid.busy_check got %0b exp 1", busy); else passes++;
    @(negedge clk_4x);
    checks++; if (done !== 1'b1) $display("[TB] FAIL valid.done got %0b exp 1", done); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL valid.busy got %0b exp 0", busy); else passes++;
    checks++; if (header_ok !== modelHeader()) $display("[TB] FAIL valid.header_ok got %0b exp %0b", header_ok, modelHeader()); else passes++;
    checks++; if (checksum_ok !== (modelSum() == 0)) $display("[TB] FAIL valid.checksum_ok got %0b exp %0b", checksum_ok, modelSum() == 0); else passes++;
    checks++; if (byte_count !== 8'd128) $display("[TB] FAIL valid.byte_count got %0d exp 128", byte_count); else passes++;
    checks++; if (timeout !== 1'b0) $display("[TB] FAIL valid.timeout got %0b exp 0", timeout); else passes++;
    rd_addr = 7'd1;
    @(negedge clk_4x);
    checks++; if (rd_data !== hdrRef[1]) $display("[TB] FAIL valid.rd_addr1 got %0h exp %0h", rd_data, hdrRef[1]); else passes++;
    for (int k = 0; k < 6; k++) begin
      a = $urandom_range(0, 127);
      rd_addr = 7'(a);
      @(negedge clk_4x);
      checks++; if (rd_data !== memModel[a]) $display("[TB] FAIL valid.read[%0d] got %0h exp %0h", a, rd_data, memModel[a]); else passes++;
    end
  endtask

  task automatic test_corrupt();
    makeBlock();
    blk[127] = blk[127] + 8'd1;
    pulseStart();
    sendBlock(128, 3);
    @(negedge clk_4x);
    checks++; if (done !== 1'b1) $display("[TB] FAIL corrupt_sum.done got %0b exp 1", done); else passes++;
    checks++; if (checksum_ok !== (modelSum() == 0)) $display("[TB] FAIL corrupt_sum.checksum_ok got %0b exp %0b", checksum_ok, modelSum() == 0); else passes++;
    checks++; if (header_ok !== modelHeader()) $display("[TB] FAIL corrupt_sum.header_ok got %0b exp %0b", header_ok, modelHeader()); else passes++;
    makeBlock();
    blk[3] = 8'hFE;
    fixChecksum();
    pulseStart();
    sendBlock(128, 3);
    @(negedge clk_4x);
    checks++; if (header_ok !== modelHeader()) $display("[TB] FAIL corrupt_hdr.header_ok got %0b exp %0b", header_ok, modelHeader()); else passes++;
    checks++; if (checksum_ok !== (modelSum() == 0)) $display("[TB] FAIL corrupt_hdr.checksum_ok got %0b exp %0b", checksum_ok, modelSum() == 0); else passes++;
  endtask

  task automatic test_timeout();
    makeBlock();
    pulseStart();
    sendBlock(40, 4);
    repeat (15) @(negedge clk_4x);
    checks++; if (timeout !== 1'b0) $display("[TB] FAIL timeout.early got %0b exp 0", timeout); else passes++;
    @(negedge clk_4x);
    checks++; if (timeout !== 1'b1) $display("[TB] FAIL timeout.flag got %0b exp 1", timeout); else passes++;
    checks++; if (done !== 1'b0) $display("[TB] FAIL timeout.done got %0b exp 0", done); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL timeout.busy got %0b exp 0", busy); else passes++;
    checks++; if (byte_count !== 8'd40) $display("[TB] FAIL timeout.byte_count got %0d exp 40", byte_count); else passes++;
    // A strobe landing on the expiry cycle must keep the capture alive.
    pulseStart();
    sendBlock(5, 2);
    repeat (15) @(negedge clk_4x);
    applyStimulus(8'h77, 5);
    checks++; if (timeout !== 1'b0) $display("[TB] FAIL byte_wins.timeout got %0b exp 0", timeout); else passes++;
    checks++; if (byte_count !== 8'd6) $display("[TB] FAIL byte_wins.byte_count got %0d exp 6", byte_count); else passes++;
    repeat (15) @(negedge clk_4x);
    checks++; if (busy !== 1'b1) $display("[TB] FAIL byte_wins.busy got %0b exp 1", busy); else passes++;
    @(negedge clk_4x);
    checks++; if (timeout !== 1'b1) $display("[TB] FAIL byte_wins.late_timeout got %0b exp 1", timeout); else passes++;
  endtask

  task automatic test_restart();
    int s = 0;
    for (int i = 0; i < 128; i++) blk[i] = 8'($urandom);
    for (int i = 0; i < 60; i++) s += blk[i];
    if (s % 256 == 0) blk[59] = blk[59] + 8'd1;
    pulseStart();
    sendBlock(60, 3);
    makeBlock();
    pulseStart();
    sendBlock(128, 3);
    @(negedge clk_4x);
    checks++; if (done !== 1'b1) $display("[TB] FAIL restart.done got %0b exp 1", done); else passes++;
    checks++; if (byte_count !== 8'd128) $display("[TB] FAIL restart.byte_count got %0d exp 128", byte_count); else passes++;
    checks++; if (checksum_ok !== (modelSum() == 0)) $display("[TB] FAIL restart.checksum_ok got %0b exp %0b", checksum_ok, modelSum() == 0); else passes++;
    checks++; if (header_ok !== modelHeader()) $display("[TB] FAIL restart.header_ok got %0b exp %0b", header_ok, modelHeader()); else passes++;
  endtask

  task automatic test_reset_mid();
    makeBlock();
    pulseStart();
    sendBlock(10, 2);
    rst = 1'b1;
    @(negedge clk_4x);
    checks++; if (busy !== 1'b0) $display("[TB] FAIL rst_mid.busy got %0b exp 0", busy); else passes++;
    checks++; if (done !== 1'b0) $display("[TB] FAIL rst_mid.done got %0b exp 0", done); else passes++;
    checks++; if (header_ok !== 1'b0 || checksum_ok !== 1'b0) $display("[TB] FAIL rst_mid.status got %0b%0b exp 00", header_ok, checksum_ok); else passes++;
    checks++; if (timeout !== 1'b0) $display("[TB] FAIL rst_mid.timeout got %0b exp 0", timeout); else passes++;
    checks++; if (byte_count !== 8'd0) $display("[TB] FAIL rst_mid.byte_count got %0d exp 0", byte_count); else passes++;
    checks++; if (rd_data !== 8'h00) $display("[TB] FAIL rst_mid.rd_data got %0h exp 0", rd_data); else passes++;
    rst = 1'b0;
    applyStimulus(8'h5A, -1);
    checks++; if (byte_count !== 8'd0) $display("[TB] FAIL idle_ignore.byte_count got %0d exp 0", byte_count); else passes++;
  endtask

  task automatic test_overflow();
    makeBlock();
    pulseStart();
    sendBlock(128, 2);
    applyStimulus(~blk[0], -1);
    applyStimulus(~blk[1], -1);
    checks++; if (done !== 1'b1) $display("[TB] FAIL overflow.done got %0b exp 1", done); else passes++;
    checks++; if (byte_count !== 8'd128) $display("[TB] FAIL overflow.byte_count got %0d exp 128", byte_count); else passes++;
    rd_addr = 7'd0;
    @(negedge clk_4x);
    checks++; if (rd_data !== memModel[0]) $display("[TB] FAIL overflow.buf0 got %0h exp %0h", rd_data, memModel[0]); else passes++;
  endtask

  task automatic test_start_coincident();
    logic [7:0] oldVal;
    start      = 1'b1;
    byte_valid = 1'b1;
    byte_data  = 8'hA5;
    @(negedge clk_4x);
    start      = 1'b0;
    byte_valid = 1'b0;
    checks++; if (byte_count !== 8'd0) $display("[TB] FAIL coincident.byte_count got %0d exp 0", byte_count); else passes++;
    checks++; if (busy !== 1'b1) $display("[TB] FAIL coincident.busy got %0b exp 1", busy); else passes++;
    rd_addr = 7'd0;
    oldVal  = memModel[0];
    applyStimulus(8'h3C, 0);
    checks++; if (byte_count !== 8'd1) $display("[TB] FAIL coincident.first_byte got %0d exp 1", byte_count); else passes++;
    checks++; if (rd_data !== oldVal) $display("[TB] FAIL rw_same_addr.old_data got %0h exp %0h", rd_data, oldVal); else passes++;
    @(negedge clk_4x);
    checks++; if (rd_data !== memModel[0]) $display("[TB] FAIL coincident.buf0 got %0h exp %0h", rd_data, memModel[0]); else passes++;
  endtask

`ifdef EDID_CAPTURE_EXT_COUNT_EN
  task automatic test_ext_count();
    makeBlock();
    blk[126] = 8'h01;
    fixChecksum();
    pulseStart();
    sendBlock(128, 3);
    @(negedge clk_4x);
    checks++; if (ext_count !== blk[126]) $display("[TB] FAIL ext.ext_count got %0h exp %0h", ext_count, blk[126]); else passes++;
    checks++; if (checksum_ok !== (modelSum() == 0)) $display("[TB] FAIL ext.checksum_ok got %0b exp %0b", checksum_ok, modelSum() == 0); else passes++;
  endtask
`endif

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    rd_addr    = 7'd0;
    hdrRef     = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00};
    @(negedge clk_4x);
    test_reset();
    test_valid_block(5);
    test_valid_block(0);
    test_corrupt();
    test_timeout();
    test_restart();
    test_reset_mid();
    test_overflow();
    test_start_coincident();
`ifdef EDID_CAPTURE_EXT_COUNT_EN
    test_ext_count();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/edid_capture.md
Name: edid_capture

Overview:
- Downstream consumer of the DDC I2C master's read-byte stream on the HDMI (gpdi) port.
- Collects one 128-byte EDID block from the master's byte/valid output (slave 7'h50) into an internal buffer.
- Validates the fixed 8-byte header and the block checksum.
- Exposes the bytes through a registered read port and pass/fail status for the display/LED logic.

Parameters:
- NUM_BYTES, 128, bytes per EDID block; a block is complete after this many accepted bytes.
- ADDR_W, 7, buffer address width; equals clog2(NUM_BYTES).
- TIMEOUT_CYCLES, 4096, maximum clk_4x cycles between consecutive bytes while capturing before aborting.

Ports:
- clk_4x  in  1  the codebase's 4x I2C clock (PLL CLKOP); all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; arms a new capture and clears all status.
- byte_valid  in  1  one-cycle strobe from the I2C master: byte_data holds a completed read byte.
- byte_data  in  8  read byte, MSB first as received on SDA.
- busy  out  1  high while a capture is in progress.
- done  out  1  level; block complete, status valid; held until the next start or rst.
- header_ok  out  1  bytes 0..7 equal 00 FF FF FF FF FF FF 00; valid when done.
- checksum_ok  out  1  8-bit sum of all NUM_BYTES bytes == 8'h00; valid when done.
- timeout  out  1  level; capture aborted because the byte gap exceeded TIMEOUT_CYCLES.
- byte_count  out  ADDR_W+1  number of bytes accepted in the current or last capture.
- rd_addr  in  ADDR_W  buffer read address.
- rd_data  out  8  buffer content at rd_addr; 1-cycle registered latency.

Behaviour:
- Reset values: state IDLE, busy=0, done=0, header_ok=0, checksum_ok=0, timeout=0, byte_count=0, rd_data=0, checksum accumulator=0. Buffer contents are not reset.
- State machine: IDLE, CAPTURE, CHECK, DONE, ABORT.
- IDLE
  - start -> CAPTURE; clear byte_count, accumulator, status flags and gap counter.
  - byte_valid is ignored.
- CAPTURE (busy=1)
  - On byte_valid:
    - write byte_data to buffer[byte_count].
    - accumulator += byte_data, mod 256.
    - header compare for index <8: header_ok tracks as a running AND.
    - byte_count++.
    - gap counter cleared.
  - When the accepted byte is number NUM_BYTES -> CHECK on the next edge.
  - Otherwise the gap counter increments each cycle; on reaching TIMEOUT_CYCLES -> ABORT.
- CHECK (busy=1, one cycle)
  - checksum_ok <= (accumulator == 0).
  - header_ok finalised.
  - -> DONE.
  - done rises exactly 2 cycles after the last byte_valid.
- DONE
  - done=1, busy=0.
  - Further byte_valid are ignored; byte_count saturates at NUM_BYTES.
  - start -> CAPTURE.
- ABORT
  - timeout=1, done=0, busy=0.
  - byte_count holds the partial count.
  - start -> CAPTURE.
- Boundary and simultaneous events:
  - start during CAPTURE or CHECK restarts the capture cleanly.
  - byte_valid in the same cycle as start is dropped; the first byte is taken on the following cycle.
  - byte_valid on the same cycle the gap counter hits TIMEOUT_CYCLES is accepted; the byte wins over the timeout.
  - rst mid-capture returns to IDLE with the reset values above; partial buffer data is left in place but is not valid.
- Read port
  - rd_data <= buffer[rd_addr] every cycle, independent of state.
  - Read and write of the same address in one cycle returns old data.
  - The buffer maps to ECP5 DP16KD/distributed RAM; no reset on the array.
- Arithmetic: accumulator is 8 bits and wraps; byte_count is ADDR_W+1 bits so NUM_BYTES is representable.

Optional Feature:
- Macro EDID_CAPTURE_EXT_COUNT_EN.
- Defined:
  - adds output ext_count[7:0], latched from byte index 126 during CAPTURE.
  - ext_count is reset to 0 and cleared on start.
  - ext_count is valid when done.
- Undefined: the port and its register are absent; behaviour otherwise identical.

Decomposition:
- Package edid_pkg:
  - state enum edid_state_t (IDLE, CAPTURE, CHECK, DONE, ABORT).
  - constant EDID_HEADER[0:7].
  - constants EDID_BLOCK_BYTES=128 and EDID_EXT_INDEX=126.
- One sub-module edid_buffer_ram: single-write, single-registered-read, NUM_BYTES x 8, inferable RAM.

Test Plan:
- Valid block: start, then 128 bytes of a legal EDID (header, byte 127 chosen so sum=00), with 3-cycle gaps -> done=1 two cycles after the last strobe, header_ok=1, checksum_ok=1, byte_count=128, rd_addr=1 reads FF one cycle later.
- Corrupt data:
  - same block with byte 127 incremented by 1 -> done=1, checksum_ok=0, header_ok=1.
  - byte 3 = FE -> header_ok=0.
- Timeout: start, 40 bytes, then silence with TIMEOUT_CYCLES=16 -> timeout=1 after 16 idle cycles, done=0, busy=0, byte_count=40.
- Restart and reset:
  - start asserted after 60 bytes, then a full valid block -> done=1, byte_count=128, checksum from the new bytes only.
  - rst at byte 10 -> all outputs return to reset values.
- Overflow and edge timing:
  - 130 strobes -> bytes 129–130 ignored, byte_count=128, buffer[0] unchanged.
  - byte_valid coincident with start -> that byte is dropped (byte_count=0 next cycle).
- Extension byte: with EDID_CAPTURE_EXT_COUNT_EN, byte 126=01 and byte 127 adjusted so the sum is 0 -> ext_count=01 at done.
